mem_bus_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory bus between the IF stage (instruction

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_timer.sv | 49 ++++
 rtl/mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default constants for the IF/MEM memory bus
//               arbiter. It provides the FSM state type, the grant encoding and
//               the default values of the arbiter parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // Arbiter FSM states. IDLE must encode as zero because reset clears it.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Owner of the bus transfer currently in flight.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // Default parameter values.
    localparam int unsigned c_def_aw          = 32;
    localparam int unsigned c_def_dw          = 32;
    localparam int unsigned c_def_timeout_cyc = 16;
    localparam int unsigned c_def_max_mem_run = 4;

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
// Module      : mem_arb_timer
// Description : Counts the bus cycles of a transfer and flags the cycle in which
//               the transfer has to be aborted because no bus_ack arrived.
//               The count starts at 0 in the first BUSY cycle, so expired is
//               raised in the TIMEOUT_CYC-th BUSY cycle.
// Ports       : clk     - clock, rising edge
//               rst     - asynchronous active-low reset
//               clr     - clear the count (takes priority over en)
//               en      - advance the count by one
//               expired - count has reached TIMEOUT_CYC-1 while enabled
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = c_def_timeout_cyc
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned        CW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]      c_last = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
        end else if (clr) begin
            r_tmo_cnt <= '0;
        end else if (en) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end

    // The owner clears the count in the same cycle it sees expired, so the
    // counter never has to wrap or saturate.
    assign expired = en && (r_tmo_cnt == c_last);

endmodule : mem_arb_timer

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-port, variable-latency memory bus between the
//               IF stage (fetch) and the MEM stage (load/store). MEM has
//               priority. A starvation guard hands the bus to IF after
//               MAX_MEM_RUN consecutive MEM grants. Transfers that see no
//               bus_ack within TIMEOUT_CYC cycles are aborted with bus_err.
// Ports       : clk, rst                    - clock / async active-low reset
//               if_req, if_addr             - fetch request (held until done)
//               if_rdata, if_done           - fetched word / completion pulse
//               mem_rd, mem_wr              - load / store request (held)
//               mem_addr, mem_wdata         - load/store address and data
//               mem_rdata, mem_done         - load data / completion pulse
//               stall                       - pipeline stall (combinational)
//               bus_req, bus_we             - registered bus request / write
//               bus_addr, bus_wdata         - registered address / write data
//               bus_rdata, bus_ack          - bus read data / completion
//               bus_err                     - pulse on timeout abort
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = c_def_aw,
    parameter int unsigned DW          = c_def_dw,
    parameter int unsigned TIMEOUT_CYC = c_def_timeout_cyc,
    parameter int unsigned MAX_MEM_RUN = c_def_max_mem_run
) (
    input  logic          clk,
    input  logic          rst,
    // IF stage
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    // MEM stage
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    // pipeline control
    output logic          stall,
    // memory bus
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          bus_err
);

    localparam int unsigned   RW         = $clog2(MAX_MEM_RUN + 1);
    localparam logic [RW-1:0] c_run_max  = RW'(MAX_MEM_RUN);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t        r_state;
    grant_t        r_gnt;
    logic [RW-1:0] r_run_cnt;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic          r_bus_err;
    logic [DW-1:0] r_mem_rdata;
    logic [DW-1:0] r_if_rdata;
    logic          r_mem_done;
    logic          r_if_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t        w_state_nxt;
    grant_t        w_winner;
    grant_t        w_grant;
    logic          w_finish;
    logic          w_abort;
    logic          w_expired;
    logic          w_mem_any;
    logic          w_run_full;

    assign w_mem_any  = mem_rd | mem_wr;
    assign w_run_full = (r_run_cnt == c_run_max);

    // Priority decision on the raw requests. MEM wins unless IF is waiting and
    // MEM has already used up its run of consecutive grants.
    always_comb begin
        w_winner = GNT_NONE;
        if (w_mem_any && !(if_req && w_run_full)) begin
            w_winner = GNT_MEM;
        end else if (if_req) begin
            w_winner = GNT_IF;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and per-cycle control
    // ------------------------------------------------------------------------
    // On a done cycle the finishing requester still shows its old request. If
    // that requester is also the priority winner, nothing is granted this
    // cycle: its held request counts as a new one only from the next cycle,
    // and the other requester does not jump the queue while MEM still has
    // priority. This keeps MEM runs consecutive so the starvation guard works.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = GNT_NONE;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_winner == GNT_MEM && !r_mem_done) ||
                    (w_winner == GNT_IF  && !r_if_done)) begin
                    w_grant     = w_winner;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    w_finish = 1'b1;
                end else if (w_expired) begin
                    w_finish = 1'b1;
                    w_abort  = 1'b1;
                end
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Timeout counter: runs during BUSY and restarts for every transfer
    // ------------------------------------------------------------------------
    mem_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     ((r_state != BUSY) || w_finish),
        .en      (r_state == BUSY),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------------
    // Bus registers, done pulses and read-data registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt       <= GNT_NONE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_mem_rdata <= '0;
            r_if_rdata  <= '0;
            r_mem_done  <= 1'b0;
            r_if_done   <= 1'b0;
        end else begin
            r_mem_done <= 1'b0;
            r_if_done  <= 1'b0;
            r_bus_err  <= 1'b0;

            if (w_grant != GNT_NONE) begin
                r_gnt     <= w_grant;
                r_bus_req <= 1'b1;
                if (w_grant == GNT_MEM) begin
                    // A simultaneous rd+wr is resolved as a store.
                    r_bus_we    <= mem_wr;
                    r_bus_addr  <= mem_addr;
                    r_bus_wdata <= mem_wr ? mem_wdata : '0;
                end else begin
                    r_bus_we    <= 1'b0;
                    r_bus_addr  <= if_addr;
                    r_bus_wdata <= '0;
                end
            end

            if (w_finish) begin
                r_gnt     <= GNT_NONE;
                r_bus_req <= 1'b0;
                r_bus_err <= w_abort;
                if (r_gnt == GNT_MEM) begin
                    r_mem_done <= 1'b1;
                    // An aborted transfer leaves a defined zero behind; a
                    // completed store keeps the previous load data.
                    if (w_abort) begin
                        r_mem_rdata <= '0;
                    end else if (!r_bus_we) begin
                        r_mem_rdata <= bus_rdata;
                    end
                end else if (r_gnt == GNT_IF) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_abort ? '0 : bus_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Starvation guard: consecutive MEM grants while IF is waiting
    // ------------------------------------------------------------------------
    // The count only means something while IF is waiting, so an idle IF
    // clears it even on a MEM grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant == GNT_IF || !if_req) begin
                r_run_cnt <= '0;
            end else if (w_grant == GNT_MEM && !w_run_full) begin
                r_run_cnt <= r_run_cnt + RW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall     = (w_mem_any & ~r_mem_done) | (if_req & ~r_if_done);
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_err   = r_bus_err;
    assign mem_rdata = r_mem_rdata;
    assign if_rdata  = r_if_rdata;
    assign mem_done  = r_mem_done;
    assign if_done   = r_if_done;

endmodule : mem_bus_arbiter

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Expected bus grants
//               and completions are queued when a request is driven and are
//               compared when the DUT raises bus_req or a done pulse. A small
//               bus responder acknowledges each grant after the latency stored
//               with the expected grant (0 = never, forcing a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_rd, mem_wr, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_done, mem_done, stall, bus_req, bus_we, bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW          (32),
        .DW          (32),
        .TIMEOUT_CYC (TMO),
        .MAX_MEM_RUN (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          lat;
    } gnt_t;

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } done_t;

    gnt_t        gq[$];
    done_t       dq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          g_cyc    = 0;
    int          resp_cnt = 0;
    int          drv_lat  = 0;
    logic [31:0] drv_rsp  = '0;
    logic [31:0] cur_addr = '0;
    logic        prev_req = 1'b0;
    int          mem_left = 0;
    int          if_left  = 0;
    logic [31:0] m_mem_rdata = '0;
    logic [31:0] m_if_rdata  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Queue one expected transfer: its bus grant and its completion.
    task automatic exp_xfer(input logic is_mem, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rsp, input int lat);
        gnt_t  g;
        done_t d;
        g.we    = we;
        g.addr  = addr;
        g.wdata = we ? wdata : 32'h0;
        g.rsp   = rsp;
        g.lat   = lat;
        gq.push_back(g);
        d.is_mem = is_mem;
        d.err    = (lat == 0);
        d.lat    = (lat == 0) ? TMO : lat;
        if (is_mem) begin
            if (lat == 0)   m_mem_rdata = 32'h0;
            else if (!we)   m_mem_rdata = rsp;
            d.rdata = m_mem_rdata;
        end else begin
            m_if_rdata = (lat == 0) ? 32'h0 : rsp;
            d.rdata    = m_if_rdata;
        end
        dq.push_back(d);
    endtask

    // One clock: sample #1 after the edge, check, then drive the next inputs.
    task automatic tick();
        done_t d;
        gnt_t  g;
        @(posedge clk);
        #1;
        cyc++;
        // completion monitor
        if (mem_done || if_done) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'(mem_done | if_done), 32'h0);
            end else begin
                d = dq.pop_front();
                chk("done_kind", 32'(mem_done), 32'(d.is_mem));
                chk("done_rdata", mem_done ? mem_rdata : if_rdata, d.rdata);
                chk("done_err", 32'(bus_err), 32'(d.err));
                chk("done_latency", 32'(cyc - g_cyc), 32'(d.lat));
                chk("done_busreq_low", 32'(bus_req), 32'h0);
                chk("done_stall", 32'(stall), mem_done ? 32'(if_req) : 32'(mem_rd | mem_wr));
            end
            if (mem_done) begin
                mem_left--;
                if (mem_left <= 0) begin
                    mem_rd = 1'b0;
                    mem_wr = 1'b0;
                end
            end
            if (if_done) begin
                if_left--;
                if (if_left <= 0) if_req = 1'b0;
            end
        end else begin
            chk("err_without_done", 32'(bus_err), 32'h0);
        end
        // grant monitor
        if (bus_req && !prev_req) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", 32'(bus_req), 32'h0);
            end else begin
                g = gq.pop_front();
                chk("grant_we", 32'(bus_we), 32'(g.we));
                chk("grant_addr", bus_addr, g.addr);
                chk("grant_wdata", bus_wdata, g.wdata);
                g_cyc    = cyc;
                drv_lat  = g.lat;
                drv_rsp  = g.rsp;
                cur_addr = g.addr;
                resp_cnt = 0;
            end
        end else if (bus_req) begin
            chk("bus_addr_stable", bus_addr, cur_addr);
        end
        prev_req = bus_req;
        // bus responder
        bus_ack   = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
        if (bus_req) begin
            resp_cnt++;
            if (drv_lat != 0 && resp_cnt == drv_lat) begin
                bus_ack   = 1'b1;
                bus_rdata = drv_rsp;
            end
        end
    endtask

    task automatic run_quiet(input int budget);
        int n = 0;
        while ((gq.size() != 0 || dq.size() != 0 || mem_rd || mem_wr || if_req) && n < budget) begin
            tick();
            n++;
        end
        chk("cycle_budget_ok", 32'(n < budget), 32'h1);
        tick();
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bus_req"},   32'(bus_req),  32'h0);
        chk({tag, "_bus_we"},    32'(bus_we),   32'h0);
        chk({tag, "_bus_addr"},  bus_addr,      32'h0);
        chk({tag, "_bus_wdata"}, bus_wdata,     32'h0);
        chk({tag, "_bus_err"},   32'(bus_err),  32'h0);
        chk({tag, "_mem_done"},  32'(mem_done), 32'h0);
        chk({tag, "_if_done"},   32'(if_done),  32'h0);
        chk({tag, "_mem_rdata"}, mem_rdata,     32'h0);
        chk({tag, "_if_rdata"},  if_rdata,      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        bus_ack   = 1'b0;
        if_addr   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_rdata = 32'hBAD0_BAD0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        chk("reset_stall", 32'(stall), 32'h0);
        #2 rst = 1'b1;
        tick();
        tick();

        // 1: lone MEM load, ack in the second BUSY cycle
        exp_xfer(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
        mem_addr = 32'h100;
        mem_rd   = 1'b1;
        mem_left = 1;
        #1 chk("t1_stall_pending", 32'(stall), 32'h1);
        run_quiet(100);
        chk("t1_rdata_hold", mem_rdata, 32'hDEAD_BEEF);

        // 2: simultaneous IF fetch and MEM store, MEM served first
        exp_xfer(1'b1, 1'b1, 32'h200, 32'h1234_5678, 32'h0, 1);
        exp_xfer(1'b0, 1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, 1);
        mem_addr  = 32'h200;
        mem_wdata = 32'h1234_5678;
        mem_wr    = 1'b1;
        mem_left  = 1;
        if_addr   = 32'h400;
        if_req    = 1'b1;
        if_left   = 1;
        run_quiet(100);
        chk("t2_mem_rdata_kept", mem_rdata, 32'hDEAD_BEEF);

        // 3: starvation guard - 4 MEM, 1 IF, then MEM resumes
        for (int i = 1; i <= 4; i++) exp_xfer(1'b1, 1'b0, 32'h300, 32'h0, 32'h3000_0000 + 32'(i), 1);
        exp_xfer(1'b0, 1'b0, 32'h500, 32'h0, 32'h5000_0001, 2);
        for (int i = 5; i <= 6; i++) exp_xfer(1'b1, 1'b0, 32'h300, 32'h0, 32'h3000_0000 + 32'(i), 1);
        mem_addr = 32'h300;
        mem_rd   = 1'b1;
        mem_left = 6;
        if_addr  = 32'h500;
        if_req   = 1'b1;
        if_left  = 1;
        run_quiet(300);

        // 4: timeout, bus_ack never comes
        exp_xfer(1'b1, 1'b0, 32'h600, 32'h0, 32'h1111_2222, 0);
        mem_addr = 32'h600;
        mem_rd   = 1'b1;
        mem_left = 1;
        run_quiet(100);
        chk("t4_mem_rdata_zero", mem_rdata, 32'h0);

        // stray bus_ack while IDLE is ignored
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("idle_ack_mem_rdata", mem_rdata, m_mem_rdata);
        chk("idle_ack_if_rdata", if_rdata, m_if_rdata);
        chk("idle_ack_bus_req", 32'(bus_req), 32'h0);

        // mem_rd and mem_wr together resolve to a store
        exp_xfer(1'b1, 1'b1, 32'h700, 32'hA5A5_5A5A, 32'h0000_0077, 3);
        mem_addr  = 32'h700;
        mem_wdata = 32'hA5A5_5A5A;
        mem_rd    = 1'b1;
        mem_wr    = 1'b1;
        mem_left  = 1;
        run_quiet(100);

        // 5: asynchronous reset in the middle of a transfer
        exp_xfer(1'b1, 1'b0, 32'h800, 32'h0, 32'h0, 0);
        mem_addr = 32'h800;
        mem_rd   = 1'b1;
        mem_left = 1;
        repeat (4) tick();
        chk("t5_busy_before_reset", 32'(bus_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        check_zero("t5");
        chk("t5_stall_held_req", 32'(stall), 32'h1);
        gq.delete();
        dq.delete();
        prev_req    = 1'b0;
        m_mem_rdata = '0;
        m_if_rdata  = '0;
        tick();
        tick();
        exp_xfer(1'b1, 1'b0, 32'h800, 32'h0, 32'h55AA_1234, 1);
        #2 rst = 1'b1;
        run_quiet(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_bus_arbiter

`default_nettype wire
